// File: rtl/antilog_calculator.sv
// antilog_calculator
//   Mitchell-style antilog: out_data = floor(2**k * (1 + f)), computed by a
//   bit-serial shifter that moves the accumulator left one place per cycle.
//   A request is taken in IDLE, shifted k times in SHIFT, and the result is
//   held in DONE until the consumer takes it.
//
// Parameters
//   FRAC_W  fraction width of in_frac (weight 2**-FRAC_W per LSB)
//   CHAR_W  characteristic width; result width OUT_W = 2**CHAR_W
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   request qualifier for in_char / in_frac
//   in_ready   high only in IDLE
//   in_char    characteristic k
//   in_frac    fraction f
//   out_valid  high only in DONE
//   out_ready  consumer accepts out_data
//   out_data   registered result, kept until the next result is written
//
// Build option
//   ANTILOG_BIAS_COMP_EN  when defined, adds a constant +5 bias to the
//                         fraction, saturating at 2**FRAC_W-1.

module antilog_calculator #(
    parameter int FRAC_W = 7,
    parameter int CHAR_W = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [CHAR_W-1:0]        in_char,
    input  logic [FRAC_W-1:0]        in_frac,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [(2**CHAR_W)-1:0]   out_data
);

    localparam int OUT_W = 2**CHAR_W;
    // Wide enough that the largest shift (k = 2**CHAR_W-1) keeps every bit.
    localparam int ACC_W = FRAC_W + OUT_W;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t              state_q, state_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [CHAR_W-1:0]   cnt_q, cnt_d;
    logic [OUT_W-1:0]    out_data_q, out_data_d;
    logic [FRAC_W-1:0]   f_eff;

`ifdef ANTILOG_BIAS_COMP_EN
    // One spare bit catches the carry; a carry means the sum exceeded the
    // largest fraction, so clamp to all-ones.
    logic [FRAC_W:0] frac_sum;
    always_comb begin
        frac_sum = {1'b0, in_frac} + (FRAC_W+1)'(5);
        f_eff    = frac_sum[FRAC_W] ? {FRAC_W{1'b1}} : frac_sum[FRAC_W-1:0];
    end
`else
    assign f_eff = in_frac;
`endif

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_data  = out_data_q;

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        out_data_d = out_data_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // Hidden leading one makes the mantissa 1.f.
                    acc_d   = {{(ACC_W-FRAC_W-1){1'b0}}, 1'b1, f_eff};
                    cnt_d   = in_char;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q != '0) begin
                    acc_d = {acc_q[ACC_W-2:0], 1'b0};
                    cnt_d = cnt_q - CHAR_W'(1);
                end else begin
                    // Dropping the low FRAC_W bits is the floor of 2**k*(1+f).
                    out_data_d = acc_q[ACC_W-1:FRAC_W];
                    state_d    = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            cnt_q      <= '0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            out_data_q <= out_data_d;
        end
    end

endmodule
